led_scan_ctrl: RTL
==================

// Module: led_scan_ctrl
// PURPOSE
//   Scan sequencer for the 2x(60x16) RGB LED matrix. Generates col/row indices feeding the
//   pixel data driver, plus panel shift clock, latch, output-enable and row address.
//   Per row: shift COLS pixels, blank, latch, display for DWELL cycles; rows 0..ROWS-1 per frame.
//   Sits between the game-state/frame buffers (via the data driver) and the panel pins.
// PARAMETERS
//   COLS     60   pixels shifted per row (col range 0..COLS-1)
//   ROWS     16   scan rows per frame (row range 0..ROWS-1)
//   CLK_DIV  2    clk cycles per panel_clk half-period (>=1)
//   DWELL    64   clk cycles panel_oe_n held low per row (>=1)
// PORTS
//   clk         in   1  system clock
//   rst         in   1  reset, asynchronous, active-high
//   en          in   1  scanning enable
//   col         out  7  current pixel column to data driver
//   row         out  4  row being shifted, to data driver
//   panel_clk   out  1  panel shift clock
//   panel_lat   out  1  panel latch strobe
//   panel_oe_n  out  1  panel output enable, active-low
//   addr        out  4  displayed row address (panel A..D)
//   frame_done  out  1  1-cycle pulse at end of row ROWS-1 display
//   busy        out  1  high whenever state != IDLE
// BEHAVIOUR
//   Reset: state IDLE; col=0, row=0, panel_clk=0, panel_lat=0, panel_oe_n=1, addr=0,
//     frame_done=0, busy=0; all timers cleared. Takes effect immediately, incl. mid-row.
//   All outputs registered. States: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
//   IDLE: outputs at reset values except row/addr hold; en=1 -> SHIFT with col=0, row=0.
//   SHIFT: each pixel lasts 2*CLK_DIV cycles; panel_clk=0 first CLK_DIV, 1 last CLK_DIV
//     (rising edge mid-pixel, data settled). After pixel COLS-1 -> BLANK, panel_clk=0, col=0.
//   BLANK: 1 cycle, panel_oe_n=1 -> LATCH.
//   LATCH: 1 cycle, panel_lat=1, addr<=row -> DISPLAY.
//   DISPLAY: panel_oe_n=0 for exactly DWELL cycles, then panel_oe_n=1 and:
//     row<ROWS-1: row<=row+1; row=ROWS-1: row<=0 (wrap), frame_done=1 same cycle.
//     en=1 -> SHIFT; en=0 -> IDLE.
//   en sampled only in IDLE and at DISPLAY exit; deassertion mid-row completes the row.
//   Row period = 2*CLK_DIV*COLS + 2 + DWELL cycles (defaults: 306). Frame = ROWS*that.
//   panel_oe_n is never low in SHIFT/BLANK/LATCH; panel_lat never high with panel_oe_n low.
//   col never exceeds COLS-1; row never exceeds ROWS-1; counters wrap, never overflow.
// STRUCTURE
//   led_matrix_pkg: COLS, ROWS defaults, scan_state_t enum {IDLE,SHIFT,BLANK,LATCH,DISPLAY}.
//   Sub-module led_scan_timer: loadable down-counter with zero flag, used for half-period
//     and DWELL timing; FSM + col/row counters in this module.
// TESTING
//   rst pulse then en=1 -> first panel_clk rise at cycle CLK_DIV after SHIFT entry, col=0.
//   Full row, defaults -> exactly 60 panel_clk rises, lat pulse at cycle 241, oe_n low 64 cycles.
//   Run 16 rows -> addr steps 0..15, row wraps to 0, frame_done single pulse at cycle 16*306.
//   en dropped mid-SHIFT row 5 -> row 5 finishes, DISPLAY runs 64 cycles, then IDLE, busy=0.
//   rst asserted mid-DISPLAY -> same cycle outputs: oe_n=1, lat=0, panel_clk=0, col=row=addr=0.
//   CLK_DIV=1, DWELL=1 -> row period 123 cycles; oe_n/lat mutual exclusion asserted throughout.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix scan path: panel geometry defaults,
// the scan state encoding and small constant helpers.
package led_matrix_pkg;

    localparam int LED_COLS    = 60;
    localparam int LED_ROWS    = 16;
    localparam int LED_CLK_DIV = 2;
    localparam int LED_DWELL   = 64;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..v-1 (at least one bit).
    function automatic int cnt_width(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Loadable down-counter with a zero flag. Shared by the scan FSM for the
// panel_clk half-period and the per-row display dwell.
module led_scan_timer
    import led_matrix_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Load has priority over decrement; the counter parks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/led_scan_ctrl.sv
// Scan sequencer for the RGB LED matrix: per row it shifts COLS pixels with
// panel_clk, blanks, latches, then displays for DWELL cycles. All outputs are
// registered; the next values are computed in one combinational block.
module led_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int COLS    = LED_COLS,
    parameter int ROWS    = LED_ROWS,
    parameter int CLK_DIV = LED_CLK_DIV,
    parameter int DWELL   = LED_DWELL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [6:0] col,
    output logic [3:0] row,
    output logic       panel_clk,
    output logic       panel_lat,
    output logic       panel_oe_n,
    output logic [3:0] addr,
    output logic       frame_done,
    output logic       busy
);

    localparam int TW = cnt_width(max_int(CLK_DIV, DWELL));
    localparam logic [TW-1:0] HALF_LOAD  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL - 1);
    localparam logic [6:0]    COL_LAST   = 7'(COLS - 1);
    localparam logic [3:0]    ROW_LAST   = 4'(ROWS - 1);

    scan_state_t   state, state_next;
    logic [6:0]    col_next;
    logic [3:0]    row_next;
    logic [3:0]    addr_next;
    logic          panel_clk_next;
    logic          panel_lat_next;
    logic          panel_oe_n_next;
    logic          frame_done_next;
    logic          t_load;
    logic          t_dec;
    logic          t_zero;
    logic [TW-1:0] t_val;

    led_scan_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (t_load),
        .load_val(t_val),
        .dec     (t_dec),
        .zero    (t_zero)
    );

    // Next-state and next-output decode; strobes default inactive, the rest hold.
    always_comb begin
        state_next      = state;
        col_next        = col;
        row_next        = row;
        addr_next       = addr;
        panel_clk_next  = panel_clk;
        panel_lat_next  = 1'b0;
        panel_oe_n_next = 1'b1;
        frame_done_next = 1'b0;
        t_load          = 1'b0;
        t_dec           = 1'b0;
        t_val           = HALF_LOAD;

        case (state)
            IDLE: begin
                if (en) begin
                    state_next     = SHIFT;
                    col_next       = '0;
                    row_next       = '0;
                    panel_clk_next = 1'b0;
                    t_load         = 1'b1;
                end
            end
            SHIFT: begin
                if (!t_zero) begin
                    t_dec = 1'b1;
                end else if (!panel_clk) begin
                    // Low half done: rise mid-pixel so data is settled.
                    panel_clk_next = 1'b1;
                    t_load         = 1'b1;
                end else if (col == COL_LAST) begin
                    state_next     = BLANK;
                    panel_clk_next = 1'b0;
                    col_next       = '0;
                end else begin
                    col_next       = col + 7'd1;
                    panel_clk_next = 1'b0;
                    t_load         = 1'b1;
                end
            end
            BLANK: begin
                state_next     = LATCH;
                panel_lat_next = 1'b1;
                addr_next      = row;
            end
            LATCH: begin
                state_next      = DISPLAY;
                panel_oe_n_next = 1'b0;
                t_val           = DWELL_LOAD;
                t_load          = 1'b1;
            end
            DISPLAY: begin
                if (!t_zero) begin
                    panel_oe_n_next = 1'b0;
                    t_dec           = 1'b1;
                end else begin
                    if (row == ROW_LAST) begin
                        row_next        = '0;
                        frame_done_next = 1'b1;
                    end else begin
                        row_next = row + 4'd1;
                    end
                    if (en) begin
                        state_next     = SHIFT;
                        col_next       = '0;
                        panel_clk_next = 1'b0;
                        t_load         = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the panel dark immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            addr       <= '0;
            panel_clk  <= 1'b0;
            panel_lat  <= 1'b0;
            panel_oe_n <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            col        <= col_next;
            row        <= row_next;
            addr       <= addr_next;
            panel_clk  <= panel_clk_next;
            panel_lat  <= panel_lat_next;
            panel_oe_n <= panel_oe_n_next;
            frame_done <= frame_done_next;
            busy       <= (state_next != IDLE);
        end
    end

endmodule
